// File: rtl/brownout_evt_mon.sv
// Brown-out event monitor: synchronises the one-shot output, sequences the
// active-low system reset with a programmable hold, and counts events.
module brownout_evt_mon #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 8
) (
  input  logic              osc_ck,
  input  logic              rsb,
  input  logic              bo_in,
  input  logic [HOLD_W-1:0] hold_cfg,
  input  logic              clr_req,
  output logic              clr_ack,
  output logic              rst_out_n,
  output logic              rst_done,
  output logic              bo_sticky,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10,
    BAD    = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   bo_s;
  logic                   bo_p;
  logic                   evt;
  logic                   clr;
  state_t                 state_q;
  state_t                 state_d;
  logic [HOLD_W-1:0]      hold_q;
  logic [HOLD_W-1:0]      hold_d;
  logic [CNT_W-1:0]       cnt_inc;

  assign bo_s  = sync_q[SYNC_STAGES-1];
  assign evt   = bo_s & ~bo_p;
  assign clr   = clr_req & ~clr_ack;
  assign state = state_q;

  always_ff @(posedge osc_ck) begin
    if (!rsb) begin
      sync_q <= '0;
      bo_p   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bo_in};
      bo_p   <= bo_s;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bo_s) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!bo_s) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (bo_s) begin
          state_d = ACTIVE;
          hold_d  = '0;
        end else if (hold_q >= hold_cfg) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge osc_ck) begin
    if (!rsb) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      rst_out_n <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rst_out_n <= (state_d == IDLE);
      rst_done  <= (state_q == HOLD) && (state_d == IDLE);
    end
  end

  // counter saturates at all-ones instead of wrapping
  assign cnt_inc = (&evt_cnt) ? evt_cnt : evt_cnt + CNT_W'(1);

  always_ff @(posedge osc_ck) begin
    if (!rsb) begin
      bo_sticky <= 1'b0;
      evt_cnt   <= '0;
      clr_ack   <= 1'b0;
    end else begin
      clr_ack <= clr_req;
      if (evt) begin
        bo_sticky <= 1'b1;
        evt_cnt   <= clr ? CNT_W'(1) : cnt_inc;
      end else if (clr) begin
        bo_sticky <= 1'b0;
        evt_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_brownout_evt_mon.sv
// Scoreboard bench for brownout_evt_mon: a behavioural model predicts every
// cycle's outputs, a monitor process compares them after each edge.
module tb_brownout_evt_mon;

  localparam int S    = 2;
  localparam int HW   = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic         rst_n;
    logic         done;
    logic         sticky;
    logic         ack;
    logic [1:0]   st;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rsb;
  logic          bo_in;
  logic [HW-1:0] hold_cfg;
  logic          clr_req;
  logic          clr_ack;
  logic          rst_out_n;
  logic          rst_done;
  logic          bo_sticky;
  logic [CW-1:0] evt_cnt;
  logic [1:0]    state;

  brownout_evt_mon #(
    .SYNC_STAGES(S),
    .HOLD_W(HW),
    .CNT_W(CW)
  ) dut (
    .osc_ck(clk),
    .rsb(rsb),
    .bo_in(bo_in),
    .hold_cfg(hold_cfg),
    .clr_req(clr_req),
    .clr_ack(clr_ack),
    .rst_out_n(rst_out_n),
    .rst_done(rst_done),
    .bo_sticky(bo_sticky),
    .evt_cnt(evt_cnt),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  // model: pipe holds recent bo_in samples; [S-1] is synced, [S] delayed
  int pipe[$];
  int m_mode;
  int m_held;
  int m_cnt;
  bit m_sticky;
  bit m_ack;
  bit m_rstn;
  bit m_done;

  task automatic model(input bit r, input bit b,
                       input int cfg, input bit c);
    bit bs, bp, evt, clr;
    int prev;
    if (!r) begin
      pipe = {};
      for (int i = 0; i <= S; i++) pipe.push_back(0);
      m_mode = 2; m_held = 0;
      m_rstn = 0; m_done = 0;
      m_sticky = 0; m_cnt = 0; m_ack = 0;
      return;
    end
    bs   = pipe[S-1] != 0;
    bp   = pipe[S] != 0;
    evt  = bs && !bp;
    prev = m_mode;
    if (m_mode == 0) begin
      if (bs) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!bs) begin m_mode = 2; m_held = 0; end
    end else begin
      if (bs) begin m_mode = 1; m_held = 0; end
      else if (m_held >= cfg) m_mode = 0;
      else m_held++;
    end
    clr = c && !m_ack;
    if (evt) begin
      m_sticky = 1;
      m_cnt = clr ? 1 : (m_cnt < CMAX ? m_cnt + 1 : CMAX);
    end else if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    m_ack  = c;
    m_rstn = (m_mode == 0);
    m_done = (prev == 2) && (m_mode == 0);
    pipe.push_front(int'(b));
    void'(pipe.pop_back());
  endtask

  task automatic step(input bit r, input bit b,
                      input int cfg, input bit c);
    exp_t e;
    @(negedge clk);
    rsb      = r;
    bo_in    = b;
    hold_cfg = HW'(cfg);
    clr_req  = c;
    model(r, b, cfg, c);
    e.rst_n  = m_rstn;
    e.done   = m_done;
    e.sticky = m_sticky;
    e.ack    = m_ack;
    e.st     = 2'(m_mode);
    e.cnt    = CW'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic run(input int n, input bit b,
                     input int cfg, input bit c);
    for (int i = 0; i < n; i++) step(1'b1, b, cfg, c);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (rst_out_n !== e.rst_n || rst_done !== e.done ||
          bo_sticky !== e.sticky || clr_ack !== e.ack ||
          state !== e.st || evt_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL cycle %0d @%0t: got rstn=%b done=%b stk=%b ack=%b st=%b cnt=%0d exp rstn=%b done=%b stk=%b ack=%b st=%b cnt=%0d",
                 n_vec, $time, rst_out_n, rst_done, bo_sticky, clr_ack,
                 state, evt_cnt, e.rst_n, e.done, e.sticky, e.ack,
                 e.st, e.cnt);
      end
    end
  end

  initial begin
    int cfg;
    bit b;
    bit c;
    bit r;
    int len;
    n_vec = 0;
    n_bad = 0;
    rsb = 1'b0;
    bo_in = 1'b0;
    hold_cfg = '0;
    clr_req = 1'b0;
    for (int i = 0; i <= S; i++) pipe.push_back(0);

    // power-on reset then power-on hold
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4, 1'b0);
    run(10, 1'b0, 4, 1'b0);

    // single brown-out
    run(10, 1'b1, 3, 1'b0);
    run(15, 1'b0, 3, 1'b0);

    // re-trigger during hold
    run(5, 1'b1, 20, 1'b0);
    run(6, 1'b0, 20, 1'b0);
    run(4, 1'b1, 20, 1'b0);
    run(30, 1'b0, 20, 1'b0);

    // clear handshake
    run(5, 1'b0, 20, 1'b1);
    run(4, 1'b0, 20, 1'b0);

    // saturation
    for (int p = 0; p < 260; p++) begin
      run(3, 1'b1, 0, 1'b0);
      run(3, 1'b0, 0, 1'b0);
    end
    run(4, 1'b0, 0, 1'b0);

    // clear coinciding with an event
    run(2, 1'b1, 0, 1'b0);
    run(3, 1'b1, 0, 1'b1);
    run(3, 1'b0, 0, 1'b1);
    run(3, 1'b0, 0, 1'b0);
    run(3, 1'b0, 0, 1'b1);
    run(3, 1'b0, 0, 1'b0);

    // mid-operation reset while active, bo_in still high
    run(5, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    run(4, 1'b1, 3, 1'b0);
    run(12, 1'b0, 3, 1'b0);

    // lowering hold_cfg mid-hold
    run(4, 1'b1, 50, 1'b0);
    run(12, 1'b0, 50, 1'b0);
    run(6, 1'b0, 2, 1'b0);

    // randomized traffic
    cfg = 5;
    c = 1'b0;
    for (int k = 0; k < 120; k++) begin
      len = $urandom_range(1, 25);
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) cfg = $urandom_range(0, 12);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 5) == 0) c = ~c;
        r = ($urandom_range(0, 199) != 0);
        step(r, b, cfg, c);
      end
    end
    run(30, 1'b0, 2, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles unchecked, need 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
